bcd_tick_counter: RTL and testbench

Two-digit BCD up/down counter with an internal rate divider. It produces the tens and ones digits that feed the board's 7-segment digit decoders on HEX1/HEX0, and sits directly upstream of the binary/BCD display path. On each divider tick it steps the count 00–99 with wrap-around. It supports synchronous load, enable/pause, and one-cycle Tick/Wrap status pulses for LEDR.

---
 rtl/bcd_tick_counter.sv | 115 +++++++++++
 tb/tb_bcd_tick_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: two-digit BCD up/down counter with internal rate divider.
// Drives the ones/tens digits for HEX0/HEX1 and one-cycle Tick/Wrap pulses.
// Optional feature macro: BCD_TICK_DOWN_EN -- when defined, Up selects the
// count direction and the decrement/borrow path is built; when undefined the
// block counts up only and Up is ignored.
module bcd_tick_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Up,
    input  logic       Load,
    input  logic [7:0] LoadVal,
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic       Tick,
    output logic       Wrap
);

    // Last divider value; the edge on which the divider sits here is a step edge.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [DIV_W-1:0] div_q,  div_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    // Clamp a loaded nibble so the digit registers never hold A-F.
    function automatic logic [3:0] sat9(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

`ifndef BCD_TICK_DOWN_EN
    // Direction input has no function in the up-only build.
    logic unused_up;
    assign unused_up = Up;
`endif

    // Next-state: load beats a step; divider and count hold while disabled.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        div_d  = div_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (Load) begin
            tens_d = sat9(LoadVal[7:4]);
            ones_d = sat9(LoadVal[3:0]);
            div_d  = '0;
        end else if (Enable) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
`ifdef BCD_TICK_DOWN_EN
                if (!Up) begin
                    // Decrement with borrow; 00 wraps to 99.
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        if (tens_q == 4'd0) begin
                            tens_d = 4'd9;
                            wrap_d = 1'b1;
                        end else begin
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end else
`endif
                begin
                    // Increment with carry; 99 wraps to 00.
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 4'd9) begin
                            tens_d = 4'd0;
                            wrap_d = 1'b1;
                        end else begin
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset; Tick/Wrap land with the new digits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            div_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign Digit0 = ones_q;
    assign Digit1 = tens_q;
    assign Tick   = tick_q;
    assign Wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter with TICK_DIV=4, DIV_W=2.
// Down-count expectations follow BCD_TICK_DOWN_EN when it is defined.
module tb_bcd_tick_counter;

`ifdef BCD_TICK_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       Up;
    logic       Load;
    logic [7:0] LoadVal;
    logic [3:0] Digit0;
    logic [3:0] Digit1;
    logic       Tick;
    logic       Wrap;

    int total = 0;
    int bad   = 0;

    bcd_tick_counter #(.TICK_DIV(4), .DIV_W(2)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Up      (Up),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Digit0  (Digit0),
        .Digit1  (Digit1),
        .Tick    (Tick),
        .Wrap    (Wrap)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [7:0] lv;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       tk;
        logic       wr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic up, input logic ld,
                       input logic [7:0] lv, input logic [3:0] d1, input logic [3:0] d0,
                       input logic tk, input logic wr);
        vec_t v;
        v.rst = rst; v.en = en; v.up = up; v.ld = ld; v.lv = lv;
        v.d1 = d1; v.d0 = d0; v.tk = tk; v.wr = wr;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then compare outputs #1 after the edge.
    task automatic cyc(input string name, input logic rst, input logic en, input logic up,
                       input logic ld, input logic [7:0] lv,
                       input logic [3:0] d1, input logic [3:0] d0,
                       input logic tk, input logic wr);
        logic [9:0] got;
        logic [9:0] exp;
        Reset = rst; Enable = en; Up = up; Load = ld; LoadVal = lv;
        @(posedge Clock);
        #1;
        got = {Digit1, Digit0, Tick, Wrap};
        exp = {d1, d0, tk, wr};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got digits=%h%h tick=%b wrap=%b, want digits=%h%h tick=%b wrap=%b",
                     name, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: digits=%h%h tick=%b wrap=%b", name, got[9:6], got[5:2], got[1], got[0]);
        end
    endtask

    initial begin
        int v;
        Reset = 1'b1; Enable = 1'b0; Up = 1'b1; Load = 1'b0; LoadVal = 8'h00;

        // ---------------- table: reset, 98->99->00 wrap, saturation, down/borrow
        add(1,0,1,0,8'h00, 4'd0,4'd0,0,0);
        add(1,1,1,0,8'h00, 4'd0,4'd0,0,0);
        add(0,1,1,1,8'h98, 4'd9,4'd8,0,0);
        for (int i = 0; i < 3; i++) add(0,1,1,0,8'h00, 4'd9,4'd8,0,0);
        add(0,1,1,0,8'h00, 4'd9,4'd9,1,0);
        for (int i = 0; i < 3; i++) add(0,1,1,0,8'h00, 4'd9,4'd9,0,0);
        add(0,1,1,0,8'h00, 4'd0,4'd0,1,1);
        add(0,1,1,1,8'hFC, 4'd9,4'd9,0,0);
        add(0,0,1,1,8'h3A, 4'd3,4'd9,0,0);
        add(0,0,1,1,8'hA5, 4'd9,4'd5,0,0);
        add(0,1,0,1,8'h01, 4'd0,4'd1,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,8'h00, 4'd0,4'd1,0,0);
        add(0,1,0,0,8'h00, 4'd0, DOWN_EN ? 4'd0 : 4'd2, 1, 0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,8'h00, 4'd0, DOWN_EN ? 4'd0 : 4'd2, 0, 0);
        add(0,1,0,0,8'h00, DOWN_EN ? 4'd9 : 4'd0, DOWN_EN ? 4'd9 : 4'd3, 1, DOWN_EN);
        for (int i = 0; i < 3; i++)
            add(0,1,0,0,8'h00, DOWN_EN ? 4'd9 : 4'd0, DOWN_EN ? 4'd9 : 4'd3, 0, 0);
        add(0,1,0,0,8'h00, DOWN_EN ? 4'd9 : 4'd0, DOWN_EN ? 4'd8 : 4'd4, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld,
                vecs[i].lv, vecs[i].d1, vecs[i].d0, vecs[i].tk, vecs[i].wr);
        end

        // ---------------- 40-cycle up count 00..10, carry 09->10 without Wrap
        cyc("cnt_rst0", 1,0,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("cnt_rst1", 1,0,1,0,8'h00, 4'd0,4'd0,0,0);
        for (int k = 1; k <= 40; k++) begin
            v = k / 4;
            cyc($sformatf("cnt_k%0d", k), 0,1,1,0,8'h00,
                4'(v / 10), 4'(v % 10), (k % 4) == 0, 1'b0);
        end

        // ---------------- pause: 2 enabled, 5 paused, Tick 4+5 cycles after start
        cyc("pause_rst", 1,0,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("pause_en1", 0,1,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("pause_en2", 0,1,1,0,8'h00, 4'd0,4'd0,0,0);
        for (int i = 0; i < 5; i++) cyc($sformatf("pause_off%0d", i), 0,0,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("pause_en3", 0,1,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("pause_step", 0,1,1,0,8'h00, 4'd0,4'd1,1,0);

        // ---------------- Load on the step edge suppresses the step
        cyc("ldstep_a", 0,1,1,0,8'h00, 4'd0,4'd1,0,0);
        cyc("ldstep_b", 0,1,1,0,8'h00, 4'd0,4'd1,0,0);
        cyc("ldstep_c", 0,1,1,0,8'h00, 4'd0,4'd1,0,0);
        cyc("ldstep_ld", 0,1,1,1,8'h42, 4'd4,4'd2,0,0);
        for (int i = 0; i < 3; i++) cyc($sformatf("ldstep_hold%0d", i), 0,1,1,0,8'h00, 4'd4,4'd2,0,0);
        cyc("ldstep_next", 0,1,1,0,8'h00, 4'd4,4'd3,1,0);

        // ---------------- Reset mid-period restarts the divider
        cyc("midrst_a", 0,1,1,0,8'h00, 4'd4,4'd3,0,0);
        cyc("midrst_b", 0,1,1,0,8'h00, 4'd4,4'd3,0,0);
        cyc("midrst_rst", 1,1,1,0,8'h00, 4'd0,4'd0,0,0);
        for (int i = 0; i < 3; i++) cyc($sformatf("midrst_hold%0d", i), 0,1,1,0,8'h00, 4'd0,4'd0,0,0);
        cyc("midrst_step", 0,1,1,0,8'h00, 4'd0,4'd1,1,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
